// File: rtl/id_stage_hz.sv
// ID stage: decode, register file with write-through, load-use stall,
// flush bubble and ID/EX pipeline register.
module id_stage_hz #(
  parameter int unsigned  PC_SIZE  = 10,
  parameter int unsigned  XLEN     = 8,
  parameter int unsigned  NUM_REGS = 32,
  localparam int unsigned RA_W     = $clog2(NUM_REGS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PC_SIZE-1:0] PC_in,
  input  logic [31:0]        instruction,
  input  logic               in_valid,
  input  logic               flush,
  input  logic               ex_mem_read,
  input  logic [RA_W-1:0]    ex_rd,
  input  logic               wb_write_en,
  input  logic [RA_W-1:0]    wb_reg,
  input  logic [XLEN-1:0]    wb_data,
  output logic               stall,
  output logic [RA_W-1:0]    rs1,
  output logic [RA_W-1:0]    rs2,
  output logic               id_valid,
  output logic               reg_write,
  output logic               branch,
  output logic               mem_read,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic               alu_src,
  output logic [1:0]         alu_op,
  output logic               illegal,
  output logic [RA_W-1:0]    rd_out,
  output logic [PC_SIZE-1:0] PC_out,
  output logic [XLEN-1:0]    read_data1,
  output logic [XLEN-1:0]    read_data2,
  output logic [11:0]        immediate,
  output logic [9:0]         funct
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]      opcode;
  logic            dec_reg_write, dec_alu_src, dec_mem_read, dec_mem_to_reg;
  logic            dec_mem_write, dec_branch, dec_illegal, rs2_used;
  logic [1:0]      dec_alu_op;
  logic [11:0]     dec_imm;
  logic [XLEN-1:0] opnd1, opnd2;
  logic [XLEN-1:0] rf_q [NUM_REGS];

  logic               id_valid_q, id_valid_d;
  logic               reg_write_q, reg_write_d;
  logic               branch_q, branch_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               mem_write_q, mem_write_d;
  logic               alu_src_q, alu_src_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic               illegal_q, illegal_d;
  logic [RA_W-1:0]    rd_q, rd_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [XLEN-1:0]    rdata1_q, rdata1_d;
  logic [XLEN-1:0]    rdata2_q, rdata2_d;
  logic [11:0]        imm_q, imm_d;
  logic [9:0]         funct_q, funct_d;

  assign opcode = instruction[6:0];
  assign rs1    = instruction[15 +: RA_W];
  assign rs2    = instruction[20 +: RA_W];

  // Opcode to control/immediate decode
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_write  = 1'b0;
    dec_branch     = 1'b0;
    dec_alu_op     = 2'b00;
    dec_illegal    = 1'b0;
    rs2_used       = 1'b0;
    dec_imm        = 12'h000;
    case (opcode)
      OP_R: begin
        dec_reg_write = 1'b1;
        dec_alu_op    = 2'b10;
        rs2_used      = 1'b1;
      end
      OP_I: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_op    = 2'b10;
        dec_imm       = instruction[31:20];
      end
      OP_LOAD: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_imm        = instruction[31:20];
      end
      OP_STORE: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        rs2_used      = 1'b1;
        dec_imm       = {instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        dec_branch = 1'b1;
        dec_alu_op = 2'b01;
        rs2_used   = 1'b1;
        dec_imm    = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Operand read: x0 reads zero, same-cycle write-back bypasses the array
  always_comb begin
    opnd1 = '0;
    opnd2 = '0;
    if (rs1 != '0) opnd1 = (wb_write_en && wb_reg == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != '0) opnd2 = (wb_write_en && wb_reg == rs2) ? wb_data : rf_q[rs2];
  end

  // Flush kills the decode, so it also masks the load-use stall
  assign stall = in_valid & ~flush & ex_mem_read & (ex_rd != '0) &
                 ((ex_rd == rs1) | ((ex_rd == rs2) & rs2_used));

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_write_en && wb_reg != '0) begin
      rf_q[wb_reg] <= wb_data;
    end
  end

  // ID/EX next state: bubble unless a live, unstalled instruction is present
  always_comb begin
    id_valid_d   = 1'b0;
    reg_write_d  = 1'b0;
    branch_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = 2'b00;
    illegal_d    = 1'b0;
    rd_d         = '0;
    pc_d         = '0;
    rdata1_d     = '0;
    rdata2_d     = '0;
    imm_d        = 12'h000;
    funct_d      = 10'h000;
    if (in_valid && !flush && !stall) begin
      id_valid_d   = 1'b1;
      reg_write_d  = dec_reg_write;
      branch_d     = dec_branch;
      mem_read_d   = dec_mem_read;
      mem_to_reg_d = dec_mem_to_reg;
      mem_write_d  = dec_mem_write;
      alu_src_d    = dec_alu_src;
      alu_op_d     = dec_alu_op;
      illegal_d    = dec_illegal;
      rd_d         = instruction[7 +: RA_W];
      pc_d         = PC_in;
      rdata1_d     = opnd1;
      rdata2_d     = opnd2;
      imm_d        = dec_imm;
      funct_d      = {instruction[31:25], instruction[14:12]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      id_valid_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= 2'b00;
      illegal_q    <= 1'b0;
      rd_q         <= '0;
      pc_q         <= '0;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
      imm_q        <= 12'h000;
      funct_q      <= 10'h000;
    end else begin
      id_valid_q   <= id_valid_d;
      reg_write_q  <= reg_write_d;
      branch_q     <= branch_d;
      mem_read_q   <= mem_read_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      illegal_q    <= illegal_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      rdata1_q     <= rdata1_d;
      rdata2_q     <= rdata2_d;
      imm_q        <= imm_d;
      funct_q      <= funct_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign reg_write  = reg_write_q;
  assign branch     = branch_q;
  assign mem_read   = mem_read_q;
  assign mem_to_reg = mem_to_reg_q;
  assign mem_write  = mem_write_q;
  assign alu_src    = alu_src_q;
  assign alu_op     = alu_op_q;
  assign illegal    = illegal_q;
  assign rd_out     = rd_q;
  assign PC_out     = pc_q;
  assign read_data1 = rdata1_q;
  assign read_data2 = rdata2_q;
  assign immediate  = imm_q;
  assign funct      = funct_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: default instance plus an 8-entry,
// 16-bit instance for the parameterised register file.
module tb_id_stage_hz;

  typedef struct packed {
    logic        full;
    logic        vld;
    logic        ill;
    logic [7:0]  ctl;
    logic [4:0]  rd;
    logic [9:0]  pc;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [11:0] imm;
    logic [9:0]  fn;
    logic        chk_b;
    logic [15:0] b_d1;
  } exp_t;

  localparam logic [31:0] ADD7  = 32'h000283B3; // add  x7,x5,x0
  localparam logic [31:0] ADDI4 = 32'hFFF18213; // addi x4,x3,-1
  localparam logic [31:0] SUB1  = 32'h402300B3; // sub  x1,x6,x2
  localparam logic [31:0] ADDI9 = 32'h00910093; // addi x1,x2,9
  localparam logic [31:0] SW6   = 32'h00612223; // sw   x6,4(x2)
  localparam logic [31:0] BEQ   = 32'hD43285E3; // beq  x5,x3,imm=0xEA5
  localparam logic [31:0] LW10  = 32'h1232A503; // lw   x10,0x123(x5)
  localparam logic [31:0] BAD   = 32'h0000007F;
  localparam logic [31:0] ADD8  = 32'h00000433; // add  x8,x0,x0
  localparam logic [31:0] ADDI7 = 32'h00038093; // addi x1,x7,0

  localparam logic [7:0] C_R = 8'b100000_10;
  localparam logic [7:0] C_I = 8'b110000_10;
  localparam logic [7:0] C_L = 8'b111100_00;
  localparam logic [7:0] C_S = 8'b010010_00;
  localparam logic [7:0] C_B = 8'b000001_01;

  logic        clock, reset;
  logic [9:0]  pc_in;
  logic [31:0] instr;
  logic        in_valid, flush, ex_mem_read, wb_we;
  logic [4:0]  ex_rd, wb_reg;
  logic [7:0]  wb_data;
  logic        stall, id_valid, reg_write, branch, mem_read, mem_to_reg, mem_write, alu_src, illegal;
  logic [4:0]  rs1, rs2, rd_out;
  logic [1:0]  alu_op;
  logic [9:0]  pc_out;
  logic [7:0]  rdata1, rdata2;
  logic [11:0] imm;
  logic [9:0]  funct;

  logic        b_exmr, b_we;
  logic [2:0]  b_exrd, b_wreg;
  logic [15:0] b_wdata;
  logic        b_stall, b_vld, b_rw, b_br, b_mr, b_m2r, b_mw, b_as, b_ill;
  logic [2:0]  b_rs1, b_rs2, b_rd;
  logic [1:0]  b_op;
  logic [9:0]  b_pc;
  logic [15:0] b_d1, b_d2;
  logic [11:0] b_imm;
  logic [9:0]  b_fn;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  id_stage_hz dut (
    .clock(clock), .reset(reset), .PC_in(pc_in), .instruction(instr),
    .in_valid(in_valid), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_write_en(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall(stall), .rs1(rs1), .rs2(rs2), .id_valid(id_valid),
    .reg_write(reg_write), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal),
    .rd_out(rd_out), .PC_out(pc_out), .read_data1(rdata1), .read_data2(rdata2),
    .immediate(imm), .funct(funct)
  );

  id_stage_hz #(.PC_SIZE(10), .XLEN(16), .NUM_REGS(8)) dut_b (
    .clock(clock), .reset(reset), .PC_in(pc_in), .instruction(instr),
    .in_valid(in_valid), .flush(flush), .ex_mem_read(b_exmr), .ex_rd(b_exrd),
    .wb_write_en(b_we), .wb_reg(b_wreg), .wb_data(b_wdata),
    .stall(b_stall), .rs1(b_rs1), .rs2(b_rs2), .id_valid(b_vld),
    .reg_write(b_rw), .branch(b_br), .mem_read(b_mr), .mem_to_reg(b_m2r),
    .mem_write(b_mw), .alu_src(b_as), .alu_op(b_op), .illegal(b_ill),
    .rd_out(b_rd), .PC_out(b_pc), .read_data1(b_d1), .read_data2(b_d2),
    .immediate(b_imm), .funct(b_fn)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(logic vld, logic ill, logic [7:0] ctl, int rd, int pc,
                              int d1, int d2, int im, int fn);
    exp_t e;
    e      = '0;
    e.full = 1'b1;
    e.vld  = vld;
    e.ill  = ill;
    e.ctl  = ctl;
    e.rd   = 5'(rd);
    e.pc   = 10'(pc);
    e.d1   = 8'(d1);
    e.d2   = 8'(d2);
    e.imm  = 12'(im);
    e.fn   = 10'(fn);
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t with_b(exp_t e, int v);
    exp_t r;
    r       = e;
    r.chk_b = 1'b1;
    r.b_d1  = 16'(v);
    return r;
  endfunction

  task automatic drive(int pc, logic [31:0] ins, logic v, logic fl, logic mr,
                       int xr, logic we, int wr, int wd);
    pc_in       = 10'(pc);
    instr       = ins;
    in_valid    = v;
    flush       = fl;
    ex_mem_read = mr;
    ex_rd       = 5'(xr);
    wb_we       = we;
    wb_reg      = 5'(wr);
    wb_data     = 8'(wd);
  endtask

  // Check the combinational outputs, queue the expected ID/EX result, advance
  task automatic cycle(logic exp_stall, exp_t e);
    logic [31:0] iw;
    #1;
    iw = instr;
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("rs1", 32'(rs1), 32'(iw[19:15]));
    chk("rs2", 32'(rs2), 32'(iw[24:20]));
    sb_q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: one ID/EX result per edge once stimulus has queued it
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("id_valid", 32'(id_valid), 32'(e.vld));
        chk("illegal", 32'(illegal), 32'(e.ill));
        chk("ctrl", 32'({reg_write, alu_src, mem_read, mem_to_reg, mem_write, branch, alu_op}),
            32'(e.ctl));
        if (e.full) begin
          chk("rd_out", 32'(rd_out), 32'(e.rd));
          chk("PC_out", 32'(pc_out), 32'(e.pc));
          chk("read_data1", 32'(rdata1), 32'(e.d1));
          chk("read_data2", 32'(rdata2), 32'(e.d2));
          chk("immediate", 32'(imm), 32'(e.imm));
          chk("funct", 32'(funct), 32'(e.fn));
        end
        if (e.chk_b) begin
          chk("b_id_valid", 32'(b_vld), 32'(1));
          chk("b_read_data1", 32'(b_d1), 32'(e.b_d1));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b_exmr  = 1'b0;
    b_exrd  = 3'd0;
    b_we    = 1'b0;
    b_wreg  = 3'd0;
    b_wdata = 16'h0;
    reset   = 1'b0;
    drive(10'h10, ADD7, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    cycle(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    drive(10'h14, ADD7, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(1, 0, C_R, 7, 10'h14, 0, 0, 0, 0));
    drive(10'h14, ADD7, 0, 0, 0, 0, 1, 5, 8'h3C);
    cycle(0, bub());
    drive(10'h18, ADD7, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(1, 0, C_R, 7, 10'h18, 8'h3C, 0, 0, 0));
    drive(10'h1C, ADDI4, 1, 0, 0, 0, 1, 3, 8'hA5);
    cycle(0, mk(1, 0, C_I, 4, 10'h1C, 8'hA5, 0, 12'hFFF, 10'h3F8));
    drive(10'h20, SUB1, 1, 0, 1, 6, 1, 2, 8'h11);
    cycle(1, bub());
    drive(10'h20, SUB1, 1, 0, 0, 6, 0, 0, 0);
    cycle(0, mk(1, 0, C_R, 1, 10'h20, 0, 8'h11, 0, 10'h100));
    drive(10'h24, ADDI9, 1, 0, 1, 9, 0, 0, 0);
    cycle(0, mk(1, 0, C_I, 1, 10'h24, 8'h11, 0, 9, 0));
    drive(10'h28, SW6, 1, 1, 1, 6, 1, 6, 8'h66);
    cycle(0, bub());
    drive(10'h28, SW6, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(1, 0, C_S, 4, 10'h28, 8'h11, 8'h66, 12'h004, 10'h002));
    drive(10'h2C, BEQ, 1, 0, 1, 3, 0, 0, 0);
    cycle(1, bub());
    drive(10'h2C, BEQ, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(1, 0, C_B, 11, 10'h2C, 8'h3C, 8'hA5, 12'hEA5, 10'h350));
    drive(10'h30, LW10, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(1, 0, C_L, 10, 10'h30, 8'h3C, 8'hA5, 12'h123, 10'h04A));
    drive(10'h34, BAD, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(1, 1, 0, 0, 10'h34, 0, 0, 0, 0));
    drive(10'h38, ADD8, 1, 0, 1, 0, 1, 0, 8'hFF);
    cycle(0, mk(1, 0, C_R, 8, 10'h38, 0, 0, 0, 0));
    drive(10'h3C, ADD8, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(1, 0, C_R, 8, 10'h3C, 0, 0, 0, 0));
    drive(10'h40, ADDI7, 1, 0, 0, 0, 0, 0, 0);
    b_we = 1'b1; b_wreg = 3'd7; b_wdata = 16'hBEEF;
    cycle(0, with_b(mk(1, 0, C_I, 1, 10'h40, 0, 0, 0, 0), 16'hBEEF));
    b_we = 1'b0;
    drive(10'h44, ADDI7, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, with_b(mk(1, 0, C_I, 1, 10'h44, 0, 0, 0, 0), 16'hBEEF));
    drive(10'h48, BEQ, 1, 1, 0, 0, 0, 0, 0);
    cycle(0, bub());
    reset = 1'b0;
    drive(10'h48, BEQ, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    drive(10'h4C, ADD7, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, mk(1, 0, C_R, 7, 10'h4C, 0, 0, 0, 0));
    drive(10'h50, ADDI7, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, with_b(mk(1, 0, C_I, 1, 10'h50, 0, 0, 0, 0), 0));
    drive(10'h54, ADD7, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
Parametrised instruction-decode pipeline stage for the RV32I-subset core with a narrow datapath. It decodes one 32-bit instruction per cycle, reads an internal register file with write-through bypass, generates control and immediate, and registers everything into the ID/EX boundary. Over the previous decode stage it adds a configurable data width and register count, a valid bit, load-use hazard detection with stall, branch flush, x0 hardwiring and an illegal-opcode flag. It sits between IF and EX and feeds the stall signal back to IF.

Parameters:
PC_SIZE, 10, width of the program counter.
XLEN, 8, register and datapath width in bits.
NUM_REGS, 32, register file depth (power of two, 2..32).
RA_W, $clog2(NUM_REGS), register address width (derived).

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-low reset.
PC_in  in  PC_SIZE  PC of the instruction in IF/ID.
instruction  in  32  instruction in IF/ID.
in_valid  in  1  IF/ID slot holds a real instruction.
flush  in  1  branch taken in EX: kill the current decode.
ex_mem_read  in  1  instruction currently in EX is a load.
ex_rd  in  RA_W  destination of the instruction in EX.
wb_write_en  in  1  write-back enable.
wb_reg  in  RA_W  write-back register.
wb_data  in  XLEN  write-back data.
stall  out  1  combinational: hold PC and IF/ID this cycle.
rs1, rs2  out  RA_W each  combinational: instruction[19:15], instruction[24:20], truncated to RA_W.
id_valid  out  1  ID/EX slot valid.
reg_write, branch, mem_read, mem_to_reg, mem_write, alu_src  out  1 each  registered control.
alu_op  out  2  registered ALU op class.
illegal  out  1  registered: unsupported opcode seen.
rd_out  out  RA_W  registered destination register.
PC_out  out  PC_SIZE  registered PC.
read_data1, read_data2  out  XLEN each  registered operands.
immediate  out  12  registered immediate.
funct  out  10  registered {instruction[31:25], instruction[14:12]}.

Behaviour:
- Reset (reset==0 at edge): all registered outputs 0; all register-file entries 0. Takes effect mid-stream and overrides flush/stall.
- Latency: 1 cycle from the IF/ID inputs to the ID/EX outputs.
- Opcode decode (reg_write, alu_src, mem_read, mem_to_reg, mem_write, branch, alu_op):
  - 0110011 R: 1,0,0,0,0,0,10
  - 0010011 I-ALU: 1,1,0,0,0,0,10
  - 0000011 load: 1,1,1,1,0,0,00
  - 0100011 store: 0,1,0,0,1,0,00
  - 1100011 branch: 0,0,0,0,0,1,01
  - Any other opcode: all control 0, illegal=1, id_valid=1.
- Immediate:
  - I-ALU/load: instruction[31:20].
  - Store: {instruction[31:25], instruction[11:7]}.
  - Branch: {instruction[31], instruction[7], instruction[30:25], instruction[11:8]}.
  - Otherwise: 0.
- Register file:
  - Written on the clock edge when wb_write_en && wb_reg!=0; writes to x0 are ignored.
  - Reads of x0 return 0.
  - Write-through: if wb_write_en && wb_reg==rsN && rsN!=0, operand N takes wb_data in the same cycle.
- Hazard detection:
  - Register use: rs1 is used by all five legal classes; rs2 only by R, store and branch.
  - stall = in_valid & ~flush & ex_mem_read & (ex_rd!=0) & ((ex_rd==rs1) | (ex_rd==rs2 & rs2 used)).
- Pipeline-register update priority, in order:
  1. reset
  2. flush: insert bubble
  3. stall: insert bubble
  4. ~in_valid: insert bubble
  5. otherwise load decoded values with id_valid=1
- Bubble: id_valid, illegal and all control bits 0; data, PC and immediate fields are don't-care (implementation drives 0).
- Stall persists while the hazard holds. With a single-cycle load in EX it clears after one cycle, and the same instruction then decodes normally.
- flush and stall in the same cycle: flush wins and stall is forced to 0.
- Register-file writes proceed during stall and flush.

Test Plan:
1. Reset low for 2 cycles with a valid add on the inputs -> every output is 0 and reading x5 afterwards returns 0; release reset, write x5=0x3C, decode add x7,x5,x0 -> next cycle read_data1=0x3C, read_data2=0, reg_write=1, alu_op=10, id_valid=1.
2. Write-through: wb_write_en=1, wb_reg=3, wb_data=0xA5 in the same cycle as decoding addi x4,x3,-1 -> read_data1=0xA5, immediate=0xFFF, alu_src=1.
3. Load-use: ex_mem_read=1, ex_rd=6, decode sub x1,x6,x2 -> stall=1 that cycle and the ID/EX outputs become a bubble; next cycle ex_mem_read=0 -> stall=0 and the sub issues with funct=0x100.
4. Hazard on rs2 only matters when used: ex_rd=9, load in EX, decode addi x1,x2,9 whose rs2 field=9 -> stall=0.
5. Flush and hazard together with ex_rd=6 and decode of sw x6,4(x2) -> stall=0, id_valid=0, mem_write=0; the store decodes in a later cycle with immediate=0x004.
6. Unsupported opcode 0x7F with in_valid=1 -> illegal=1, id_valid=1, all control 0. Write with wb_reg=0, wb_data=0xFF -> later reads of x0 return 0. With NUM_REGS=8 and XLEN=16, write x7=0xBEEF -> reading it returns 0xBEEF.
